// File: rtl/tdes_iter.sv
// tdes_iter: iterative triple-DES. The three DES passes share one combinational
// DES core and run one per cycle (accept -> 3 cycles -> result).
// Optional feature macro: TDES_CBC_EN adds iv/iv_load ports and a CBC chain register.
module tdes_iter #(
   parameter int KEYING = 3,
   parameter int EDE    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        e,
   input  logic [63:0] key1,
   input  logic [63:0] key2,
   input  logic [63:0] key3,
   input  logic [63:0] intext,
   output logic [63:0] outtext,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef TDES_CBC_EN
   input  logic [63:0] iv,
   input  logic        iv_load,
`endif
   output logic        busy
);

   // DES tables, 1-based bit numbers counted from the MSB
   localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                              8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                             16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                             24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                               2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   // 1 = rotate C/D by two before this round, 0 = by one
   localparam int DBL_T [16] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
   // S-boxes S1..S8, each 4 rows of 16
   localparam int SBOX_T [512] = '{
      14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
      15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
      10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
      7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
      2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
      12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
      4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
      13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

   // Single DES block operation; enc=0 applies the subkeys in reverse order
   function automatic logic [63:0] des_block(input logic [63:0] din, input logic [63:0] key,
                                             input logic enc);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] sk [16];
      logic [63:0] ip, pre, dout;
      logic [31:0] l, r, sout, pout, tmp;
      logic [47:0] ex, x;
      logic [5:0]  six;
      int          idx, sval;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int n = 0; n < 16; n++) begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
         if (DBL_T[n] != 0) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) sk[n][47-i] = cd[56-PC2_T[i]];
      end
      for (int i = 0; i < 64; i++) ip[63-i] = din[64-IP_T[i]];
      l = ip[63:32];
      r = ip[31:0];
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < 48; i++) ex[47-i] = r[32-E_T[i]];
         x = ex ^ (enc ? sk[n] : sk[15-n]);
         for (int b = 0; b < 8; b++) begin
            six  = x[47-6*b -: 6];
            idx  = b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            sval = SBOX_T[idx];
            sout[31-4*b -: 4] = sval[3:0];
         end
         for (int i = 0; i < 32; i++) pout[31-i] = sout[32-P_T[i]];
         tmp = r;
         r   = l ^ pout;
         l   = tmp;
      end
      pre = {r, l};
      for (int i = 0; i < 64; i++) dout[63-i] = pre[64-FP_T[i]];
      return dout;
   endfunction

   typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] blk_q, blk_d;
   logic [63:0] out_q, out_d;
   logic [63:0] pk1_q, pk1_d, pk2_q, pk2_d, pk3_q, pk3_d;
   logic        e_q, e_d;
   logic        accept;
   logic [63:0] ek1, ek2, ek3;
   logic [63:0] core_key, core_out;
   logic        core_enc;
   logic [63:0] chain_in, dec_chain;

   // Effective keys for the configured keying option
   always_comb begin
      ek1 = key1;
      ek2 = (KEYING == 1) ? key1 : key2;
      ek3 = (KEYING == 3) ? key3 : key1;
   end

   // Select the key and direction for the pass currently running through the core
   always_comb begin
      core_key = pk3_q;
      core_enc = e_q;
      if (state_q == P1) begin
         core_key = pk1_q;
      end else if (state_q == P2) begin
         core_key = pk2_q;
         core_enc = (EDE != 0) ? ~e_q : e_q;
      end
   end

   assign core_out = des_block(blk_q, core_key, core_enc);

`ifdef TDES_CBC_EN
   logic [63:0] chain_q, chain_d, txt_q, txt_d;

   // Chain value seen by a block accepted this cycle (iv load or the just-finished block)
   always_comb begin
      chain_in = chain_q;
      if (state_q == IDLE && iv_load) chain_in = iv;
      else if (state_q == DONE)       chain_in = e_q ? out_q : txt_q;
   end

   assign dec_chain = e_q ? 64'd0 : chain_q;

   // Chain and captured-input updates
   always_comb begin
      chain_d = chain_q;
      txt_d   = txt_q;
      if ((state_q == IDLE && iv_load) || state_q == DONE) chain_d = chain_in;
      if (accept) txt_d = intext;
   end

   // Chain state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= '0;
         txt_q   <= '0;
      end else begin
         chain_q <= chain_d;
         txt_q   <= txt_d;
      end
   end
`else
   assign chain_in  = '0;
   assign dec_chain = '0;
`endif

   // FSM next state, handshake and pass datapath
   always_comb begin
      state_d  = state_q;
      blk_d    = blk_q;
      out_d    = out_q;
      pk1_d    = pk1_q;
      pk2_d    = pk2_q;
      pk3_d    = pk3_q;
      e_d      = e_q;
      in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
      accept   = in_valid && in_ready;
      case (state_q)
         IDLE: ;
         P1: begin
            blk_d   = core_out;
            state_d = P2;
         end
         P2: begin
            blk_d   = core_out;
            state_d = P3;
         end
         P3: begin
            out_d   = core_out ^ dec_chain;
            state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         state_d = P1;
         e_d     = e;
         pk1_d   = e ? ek1 : ek3;
         pk2_d   = ek2;
         pk3_d   = e ? ek3 : ek1;
         blk_d   = intext ^ (e ? chain_in : 64'd0);
      end
   end

   // State, pass and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         blk_q   <= '0;
         out_q   <= '0;
         pk1_q   <= '0;
         pk2_q   <= '0;
         pk3_q   <= '0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         out_q   <= out_d;
         pk1_q   <= pk1_d;
         pk2_q   <= pk2_d;
         pk3_q   <= pk3_d;
         e_q     <= e_d;
      end
   end

   assign outtext   = out_q;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tdes_iter.sv
// tb_tdes_iter: directed bench for tdes_iter using published DES vectors.
// u_dut runs KEYING=3, u_k1 runs KEYING=1; both share the same inputs.
module tb_tdes_iter;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, e, out_ready;
   logic [63:0] key1, key2, key3, intext;
   logic        in_ready, out_valid, busy;
   logic [63:0] outtext;
   logic        k1_in_ready, k1_out_valid, k1_busy;
   logic [63:0] k1_outtext;
`ifdef TDES_CBC_EN
   logic [63:0] iv;
   logic        iv_load;
`endif
   int errors = 0;
   int checks = 0;

   localparam logic [63:0] KA = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] PA = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] CA = 64'h85E8_1354_0F0A_B405;

   always #5 clk = ~clk;

   tdes_iter #(.KEYING(3), .EDE(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .e(e),
      .key1(key1), .key2(key2), .key3(key3), .intext(intext), .outtext(outtext),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef TDES_CBC_EN
      .iv(iv), .iv_load(iv_load),
`endif
      .busy(busy));

   tdes_iter #(.KEYING(1), .EDE(1)) u_k1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(k1_in_ready), .e(e),
      .key1(key1), .key2(key2), .key3(key3), .intext(intext), .outtext(k1_outtext),
      .out_valid(k1_out_valid), .out_ready(out_ready),
`ifdef TDES_CBC_EN
      .iv(iv), .iv_load(iv_load),
`endif
      .busy(k1_busy));

   // Offer one block while the DUT is idle; inputs are scrambled after acceptance
   task automatic drive_block(input logic enc, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] t);
      e = enc; key1 = a; key2 = b; key3 = c; intext = t; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = ~enc; key1 = ~a; key2 = ~b; key3 = ~c; intext = ~t;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic take_output;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (outtext !== 64'd0) begin errors++; $display("FAIL reset_outtext: got %h want 0", outtext); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_des;
      int cyc;
      drive_block(1'b1, KA, 64'hA5A5_5A5A_0F0F_F0F0, 64'h1122_3344_5566_7788, PA);
      checks++; if (k1_busy !== 1'b1) begin errors++; $display("FAIL k1_busy: got %b want 1", k1_busy); end
      wait_valid(cyc);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL latency: got %0d want 3", cyc); end
      checks++; if (k1_out_valid !== 1'b1) begin errors++; $display("FAIL k1_out_valid: got %b want 1", k1_out_valid); end
      checks++; if (k1_outtext !== CA) begin errors++; $display("FAIL keying1_des: got %h want %h", k1_outtext, CA); end
      take_output;
      checks++; if (k1_out_valid !== 1'b0) begin errors++; $display("FAIL handoff_valid: got %b want 0", k1_out_valid); end
      checks++; if (k1_outtext !== CA) begin errors++; $display("FAIL outtext_hold: got %h want %h", k1_outtext, CA); end
   endtask

   task automatic test_keying3;
      logic        ve [6];
      logic [63:0] vk1 [6], vk2 [6], vk3 [6], vin [6], vexp [6];
      logic [63:0] kb, kg;
      int cyc;
      kb = 64'h0E32_9232_EA6D_0D73;
      kg = 64'hDEAD_BEEF_0123_4567;
      ve   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vk1  = '{kb, kg, kb, KA, PA, 64'd0};
      vk2  = '{kb, kg, kg, KA, PA, 64'd0};
      vk3  = '{kb, kb, kg, KA, PA, 64'd0};
      vin  = '{64'h8787_8787_8787_8787, 64'h8787_8787_8787_8787, 64'd0, CA,
               64'h4E6F_7720_6973_2074, 64'd0};
      vexp = '{64'd0, 64'd0, 64'h8787_8787_8787_8787, PA,
               64'h3FA4_0E8A_984D_4815, 64'h8CA6_4DE9_C1B1_23A7};
      for (int i = 0; i < 6; i++) begin
         drive_block(ve[i], vk1[i], vk2[i], vk3[i], vin[i]);
         wait_valid(cyc);
         checks++;
         if (outtext !== vexp[i] || cyc !== 3) begin
            errors++;
            $display("FAIL keying3_vec%0d: got %h after %0d cycles want %h after 3", i, outtext, cyc, vexp[i]);
         end
         take_output;
      end
   endtask

   task automatic test_roundtrip;
      logic [63:0] a, b, c, p, ct;
      int cyc;
      for (int i = 0; i < 3; i++) begin
         a = {$urandom, $urandom}; b = {$urandom, $urandom};
         c = {$urandom, $urandom}; p = {$urandom, $urandom};
         drive_block(1'b1, a, b, c, p);
         wait_valid(cyc);
         ct = outtext;
         checks++; if (ct === p || cyc !== 3) begin errors++; $display("FAIL roundtrip_enc%0d: got %h cyc %0d want != %h cyc 3", i, ct, cyc, p); end
         take_output;
         drive_block(1'b0, a, b, c, ct);
         wait_valid(cyc);
         checks++; if (outtext !== p) begin errors++; $display("FAIL roundtrip_dec%0d: got %h want %h", i, outtext, p); end
         take_output;
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      drive_block(1'b1, KA, KA, KA, PA);
      wait_valid(cyc);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (outtext !== CA || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d: got text %h valid %b ready %b want %h 1 0", i, outtext, out_valid, in_ready, CA);
         end
         @(posedge clk); #1;
      end
      e = 1'b1; key1 = 64'd0; key2 = 64'd0; key3 = 64'd0; intext = 64'd0;
      in_valid = 1'b1; out_ready = 1'b1;
      #3;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; intext = 64'hFFFF_FFFF_FFFF_FFFF;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy %b want 1", busy); end
      checks++; if (outtext !== CA) begin errors++; $display("FAIL b2b_hold_prev: got %h want %h", outtext, CA); end
      wait_valid(cyc);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", cyc); end
      checks++; if (outtext !== 64'h8CA6_4DE9_C1B1_23A7) begin errors++; $display("FAIL b2b_result: got %h want 8ca64de9c1b123a7", outtext); end
      take_output;
   endtask

   task automatic test_ready_ignored;
      int cyc;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_valid: got %b want 0", out_valid); end
      drive_block(1'b1, KA, KA, KA, PA);
      out_ready = 1'b1;
      wait_valid(cyc);
      checks++; if (cyc !== 3 || outtext !== CA) begin errors++; $display("FAIL ready_high_result: got %h cyc %0d want %h cyc 3", outtext, cyc, CA); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ready_high_release: valid %b busy %b want 0 0", out_valid, busy); end
   endtask

   task automatic test_reset_midflight;
      int cyc;
      int seen;
      drive_block(1'b1, KA, KA, KA, PA);
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midflight_busy: got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || outtext !== 64'd0) begin
         errors++; $display("FAIL async_reset: busy %b valid %b text %h want 0 0 0", busy, out_valid, outtext);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid || k1_out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL discarded_block: valid seen %0d times want 0", seen); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
      drive_block(1'b1, KA, 64'h0BAD_F00D_0BAD_F00D, 64'h1234_0000_5678_0000, PA);
      wait_valid(cyc);
      checks++; if (k1_outtext !== CA || cyc !== 3) begin errors++; $display("FAIL post_reset_block: got %h cyc %0d want %h cyc 3", k1_outtext, cyc, CA); end
      take_output;
   endtask

`ifdef TDES_CBC_EN
   task automatic test_cbc;
      logic [63:0] c1, c2;
      int cyc;
      iv = 64'd0; iv_load = 1'b1;
      @(posedge clk); #1;
      iv_load = 1'b0;
      drive_block(1'b1, KA, KA, KA, PA);
      wait_valid(cyc);
      c1 = k1_outtext;
      take_output;
      drive_block(1'b1, KA, KA, KA, PA);
      wait_valid(cyc);
      c2 = k1_outtext;
      take_output;
      checks++; if (c1 !== CA) begin errors++; $display("FAIL cbc_first: got %h want %h", c1, CA); end
      checks++; if (c2 === c1) begin errors++; $display("FAIL cbc_chain: got %h want != %h", c2, c1); end
      iv = 64'd0; iv_load = 1'b1;
      drive_block(1'b0, KA, KA, KA, c1);
      iv_load = 1'b0;
      wait_valid(cyc);
      checks++; if (k1_outtext !== PA) begin errors++; $display("FAIL cbc_dec1: got %h want %h", k1_outtext, PA); end
      take_output;
      drive_block(1'b0, KA, KA, KA, c2);
      wait_valid(cyc);
      checks++; if (k1_outtext !== PA) begin errors++; $display("FAIL cbc_dec2: got %h want %h", k1_outtext, PA); end
      take_output;
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; e = 1'b1;
      key1 = '0; key2 = '0; key3 = '0; intext = '0;
`ifdef TDES_CBC_EN
      iv = '0; iv_load = 1'b0;
`endif
      test_reset;
      test_single_des;
      test_keying3;
      test_roundtrip;
      test_back_to_back;
      test_ready_ignored;
      test_reset_midflight;
`ifdef TDES_CBC_EN
      test_cbc;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/tdes_iter.md
TDES_ITER -- requirements
Module: tdes_iter

Interface
REQ-001 Parameter KEYING, default 3, key option: 3 = K1/K2/K3 independent; 2 = K3 replaced by K1; 1 = all passes use K1.
REQ-002 Parameter EDE, default 1: 1 = encrypt E-D-E / decrypt D-E-D; 0 = encrypt E-E-E / decrypt D-D-D.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  block offered on intext.
REQ-006 in_ready  output  1  block accepted when in_valid & in_ready at a rising edge.
REQ-007 e  input  1  1 = encrypt, 0 = decrypt; sampled at acceptance.
REQ-008 key1, key2, key3  input  64 each  DES keys with parity bits; sampled at acceptance.
REQ-009 intext  input  64  plaintext or ciphertext block.
REQ-010 outtext  output  64  result block.
REQ-011 out_valid  output  1  outtext valid; held until out_ready.
REQ-012 out_ready  input  1  consumer takes the result when out_valid & out_ready.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 One shared combinational DES core; the three passes run sequentially through it, one pass per cycle.
REQ-015 FSM states: IDLE, P1, P2, P3, DONE; IDLE->P1 on accept, P1->P2->P3 unconditionally, P3->DONE, DONE->IDLE on out_ready with no new accept, DONE->P1 on out_ready with a new accept.
REQ-016 On accept, intext, e and the effective keys are latched; later input changes do not affect the block in flight.
REQ-017 Encrypt pass order: (K1,K2,K3), with directions E,D,E for EDE=1 and E,E,E for EDE=0.
REQ-018 Decrypt pass order: (K3,K2,K1), with directions D,E,D for EDE=1 and D,D,D for EDE=0.
REQ-019 Each pass result is registered and fed into the next pass.
REQ-020 Latency: accept at edge T0, out_valid high after edge T3, which is 3 cycles.
REQ-021 in_ready = IDLE | (DONE & out_ready); back-to-back throughput is one block per 4 cycles.
REQ-022 outtext and out_valid are stable while out_valid=1 & out_ready=0.
REQ-023 out_ready is ignored when out_valid=0.
REQ-024 outtext holds its last value after hand-off; it is zero only after reset.

Reset
REQ-025 rst asserted at any time forces IDLE, out_valid=0, busy=0, outtext=0 and clears all pass registers.
REQ-026 A block in flight when rst asserts is discarded and no partial result is ever presented.
REQ-027 in_ready=1 from the first rising edge after rst deasserts.

Configuration
REQ-028 Macro TDES_CBC_EN, when defined, adds ports iv (input, 64) and iv_load (input, 1) and a 64-bit chain register.
REQ-029 With TDES_CBC_EN, iv_load in IDLE loads chain<=iv on the next edge; iv_load in any other state is ignored; iv_load together with an accept loads iv first, then chains that block with it.
REQ-030 CBC encrypt: pass-1 input = intext ^ chain; chain <= outtext at DONE.
REQ-031 CBC decrypt: outtext = P3 result ^ chain; chain <= captured intext at DONE.
REQ-032 With TDES_CBC_EN, reset clears chain to 0.
REQ-033 Without TDES_CBC_EN, the block is pure ECB: no iv or iv_load ports and no chain register.

Verification
REQ-034 KEYING=1, EDE=1, key1=133457799BBCDFF1, encrypt 0123456789ABCDEF -> outtext 85E813540F0AB405 after 3 cycles, equal to single DES.
REQ-035 KEYING=3, random K1/K2/K3/P, encrypt then decrypt the result -> decrypt outtext equals P; each result matches the 3-pass software model.
REQ-036 out_ready held 0 for 10 cycles -> outtext and out_valid constant, in_ready=0; out_ready=1 with in_valid=1 -> next block accepted that same edge, out_valid drops to 0.
REQ-037 rst pulsed during P2 -> out_valid never asserts for that block; next block (key1=133457799BBCDFF1, KEYING=1) gives 85E813540F0AB405.
REQ-038 TDES_CBC_EN, iv=0, KEYING=1, two identical plaintexts -> two different ciphertexts; decrypting both after reloading iv=0 restores both plaintexts.
